// File: rtl/gx4000_prn_pkg.sv
// Shared types and defaults for the GX4000 printer sink.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Contents: FSM state enum, default FIFO/ack/timeout sizes, byte width and
// the FIFO level-width helper used on both the FIFO and the top-level port.
package gx4000_prn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CAPTURE  = 2'd1,
        ST_ACK      = 2'd2,
        ST_WAIT_REL = 2'd3
    } prn_state_t;

    localparam int DEF_FIFO_DEPTH     = 16;
    localparam int DEF_ACK_CYCLES     = 4;
    localparam int DEF_TIMEOUT_CYCLES = 4096;
    localparam int PRN_DATA_W         = 8;

    // Bits needed to count 0..depth inclusive.
    function automatic int lvl_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gx4000_prn_fifo.sv
// Synchronous first-word-fall-through byte FIFO for captured printer data.
// Latency: a push is visible on o_pop_dat / !o_empty the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored; full/empty are registered-state based.
// Ports:
//   clk_sys, reset_n      clock, synchronous active-low reset
//   i_push, i_push_dat    write request and byte
//   i_pop                 consume head (only acts when non-empty)
//   o_pop_dat             head byte (valid while !o_empty)
//   o_full, o_empty       status flags
//   o_level               number of bytes held
module gx4000_prn_fifo
    import gx4000_prn_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int WIDTH = PRN_DATA_W
) (
    input  logic                         clk_sys,
    input  logic                         reset_n,
    input  logic                         i_push,
    input  logic [WIDTH-1:0]             i_push_dat,
    input  logic                         i_pop,
    output logic [WIDTH-1:0]             o_pop_dat,
    output logic                         o_full,
    output logic                         o_empty,
    output logic [lvl_width(DEPTH)-1:0]  o_level
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = lvl_width(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;

    logic w_push_ok;
    logic w_pop_ok;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;
    assign o_pop_dat = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    // Storage is not reset: entries are only observable once written.
    always_ff @(posedge clk_sys) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/gx4000_printer_sink.sv
// Centronics printer endpoint: captures host bytes on strobe, acks, and queues them for a consumer.
// Latency: strobe rise at N -> busy at N+1, FIFO write end of N+1, ack N+2..N+1+ACK_CYCLES.
// Backpressure: a full FIFO stalls in CAPTURE with busy high (no ack, no loss) until the consumer pops.
// Optional build macro: GX4000_PRN_TIMEOUT_EN (strobe-release timeout; timeout_err tied low without it).
// Ports:
//   clk_sys, reset_n          clock, synchronous active-low reset
//   enable                    accept new strobes when high
//   prn_data, prn_strobe      host byte and level strobe (held until ack)
//   prn_busy, prn_ack         handshake back to the host
//   out_data, out_valid,
//   out_ready, fifo_level     FWFT consumer side of the byte FIFO
//   proto_err, timeout_err    sticky error flags, cleared by err_clr
module gx4000_printer_sink
    import gx4000_prn_pkg::*;
#(
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    parameter int ACK_CYCLES     = DEF_ACK_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                              clk_sys,
    input  logic                              reset_n,
    input  logic                              enable,
    input  logic [PRN_DATA_W-1:0]             prn_data,
    input  logic                              prn_strobe,
    output logic                              prn_busy,
    output logic                              prn_ack,
    output logic [PRN_DATA_W-1:0]             out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [lvl_width(FIFO_DEPTH)-1:0]  fifo_level,
    output logic                              proto_err,
    output logic                              timeout_err,
    input  logic                              err_clr
);

    localparam int ACW = (ACK_CYCLES > 1) ? $clog2(ACK_CYCLES) : 1;

    prn_state_t            r_state;
    prn_state_t            w_next_state;
    logic                  r_strobe_q;
    logic [PRN_DATA_W-1:0] r_hold;
    logic [ACW-1:0]        r_ack_cnt;
    logic                  r_proto_err;

    logic w_rise;
    logic w_fifo_full;
    logic w_fifo_empty;
    logic w_push;
    logic w_timeout;

    // Strobe edge detect. The register resets to 1 so a strobe already
    // high when reset releases must drop before it can be seen again.
    assign w_rise = prn_strobe & ~r_strobe_q;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_strobe_q <= 1'b1;
        end else begin
            r_strobe_q <= prn_strobe;
        end
    end

    // Full is the registered pre-pop state, so a pop while full only frees
    // room for the following cycle.
    assign w_push = (r_state == ST_CAPTURE) & ~w_fifo_full;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_rise && enable) begin
                    w_next_state = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (!w_fifo_full) begin
                    w_next_state = ST_ACK;
                end
            end
            ST_ACK: begin
                if (r_ack_cnt == '0) begin
                    w_next_state = ST_WAIT_REL;
                end
            end
            ST_WAIT_REL: begin
                if (!prn_strobe || w_timeout) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        prn_busy = 1'b0;
        prn_ack  = 1'b0;
        case (r_state)
            ST_IDLE:     begin prn_busy = 1'b0; prn_ack = 1'b0; end
            ST_CAPTURE:  begin prn_busy = 1'b1; prn_ack = 1'b0; end
            ST_ACK:      begin prn_busy = 1'b1; prn_ack = 1'b1; end
            ST_WAIT_REL: begin prn_busy = 1'b1; prn_ack = 1'b0; end
            default:     begin prn_busy = 1'b0; prn_ack = 1'b0; end
        endcase
    end

    // Hold register and ack-length counter. Reset drops any byte in flight.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_hold    <= '0;
            r_ack_cnt <= '0;
        end else begin
            if (r_state == ST_IDLE && w_rise && enable) begin
                r_hold <= prn_data;
            end
            if (w_push) begin
                r_ack_cnt <= ACW'(ACK_CYCLES - 1);
            end else if (r_state == ST_ACK && r_ack_cnt != '0) begin
                r_ack_cnt <= r_ack_cnt - ACW'(1);
            end
        end
    end

    // Sticky protocol error; a same-cycle set beats the clear.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_proto_err <= 1'b0;
        end else if (w_rise && r_state != ST_IDLE) begin
            r_proto_err <= 1'b1;
        end else if (err_clr) begin
            r_proto_err <= 1'b0;
        end
    end

    assign proto_err = r_proto_err;

`ifdef GX4000_PRN_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [TW-1:0] r_to_cnt;
    logic          r_timeout_err;

    // Counts cycles spent in WAIT_REL; fires on the last allowed cycle with
    // strobe still high. strobe_q remains 1, so no re-capture follows until
    // the host drops and re-raises strobe.
    assign w_timeout = (r_state == ST_WAIT_REL) && prn_strobe &&
                       (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            r_to_cnt      <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            if (r_state == ST_WAIT_REL && !w_timeout) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end else begin
                r_to_cnt <= '0;
            end
            if (w_timeout) begin
                r_timeout_err <= 1'b1;
            end else if (err_clr) begin
                r_timeout_err <= 1'b0;
            end
        end
    end

    assign timeout_err = r_timeout_err;
`else
    // WAIT_REL waits for the host indefinitely in this build.
    logic w_unused_to;
    assign w_unused_to = (TIMEOUT_CYCLES > 0);
    assign w_timeout   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    gx4000_prn_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (PRN_DATA_W)
    ) u_fifo (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .i_push     (w_push),
        .i_push_dat (r_hold),
        .i_pop      (out_ready),
        .o_pop_dat  (out_data),
        .o_full     (w_fifo_full),
        .o_empty    (w_fifo_empty),
        .o_level    (fifo_level)
    );

    assign out_valid = ~w_fifo_empty;

endmodule

// File: tb/tb_gx4000_printer_sink.sv
// Directed self-checking bench for gx4000_printer_sink (default parameters).
// Inputs change and outputs are sampled 1 ns after each rising clock edge.
module tb_gx4000_printer_sink;
    import gx4000_prn_pkg::*;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       enable;
    logic [7:0] prn_data;
    logic       prn_strobe;
    logic       prn_busy;
    logic       prn_ack;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] fifo_level;
    logic       proto_err;
    logic       timeout_err;
    logic       err_clr;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    gx4000_printer_sink dut (
        .clk_sys     (clk_sys),
        .reset_n     (reset_n),
        .enable      (enable),
        .prn_data    (prn_data),
        .prn_strobe  (prn_strobe),
        .prn_busy    (prn_busy),
        .prn_ack     (prn_ack),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .fifo_level  (fifo_level),
        .proto_err   (proto_err),
        .timeout_err (timeout_err),
        .err_clr     (err_clr)
    );

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    // Full host handshake: raise strobe, wait for ack, drop strobe, wait for idle.
    task automatic send_byte(input logic [7:0] d);
        prn_data   = d;
        prn_strobe = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (prn_ack) break;
            tick();
        end
        n_assert++;
        if (prn_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ack_wait: byte %h ack=%b want 1 within 60 cycles", d, prn_ack);
        end
        prn_strobe = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (!prn_busy) break;
            tick();
        end
        n_assert++;
        if (prn_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL send_busy_wait: byte %h busy=%b want 0 within 60 cycles", d, prn_busy);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; enable = 1'b1; prn_data = 8'hEE; prn_strobe = 1'b1;
        out_ready = 1'b0; err_clr = 1'b0;
        repeat (3) tick();
        n_assert++; if (prn_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", prn_busy); end
        n_assert++; if (prn_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", prn_ack); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        n_assert++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL reset_level: got %0d want 0", fifo_level); end
        n_assert++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL reset_proto: got %b want 0", proto_err); end
        n_assert++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    endtask

    task automatic test_strobe_held();
        // Strobe is still high from reset: it must be ignored.
        reset_n = 1'b1;
        repeat (4) tick();
        n_assert++; if (prn_busy !== 1'b0) begin n_fail++; $display("FAIL held_busy: got %b want 0", prn_busy); end
        n_assert++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL held_level: got %0d want 0", fifo_level); end
        prn_strobe = 1'b0;
        tick();
        send_byte(8'h33);
        n_assert++; if (fifo_level !== 5'd1) begin n_fail++; $display("FAIL held_cap_level: got %0d want 1", fifo_level); end
        n_assert++; if (out_data !== 8'h33) begin n_fail++; $display("FAIL held_cap_data: got %h want 33", out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_assert++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL held_pop_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_single_byte();
        prn_data = 8'h5A; prn_strobe = 1'b1;                  // cycle N
        n_assert++; if (prn_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_N: got %b want 0", prn_busy); end
        tick();                                               // N+1
        n_assert++; if (prn_busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_N1: got %b want 1", prn_busy); end
        n_assert++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_N1: got %b want 0", out_valid); end
        tick();                                               // N+2
        n_assert++; if (prn_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_N2: got %b want 1", prn_ack); end
        n_assert++; if (out_valid !== 1'b1 || out_data !== 8'h5A) begin n_fail++; $display("FAIL single_out_N2: got v=%b d=%h want v=1 d=5a", out_valid, out_data); end
        prn_strobe = 1'b0;
        for (int c = 3; c <= 5; c++) begin                    // N+3..N+5
            tick();
            n_assert++; if (prn_ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_N%0d: got %b want 1", c, prn_ack); end
        end
        tick();                                               // N+6
        n_assert++; if (prn_ack !== 1'b0 || prn_busy !== 1'b1) begin n_fail++; $display("FAIL single_N6: got ack=%b busy=%b want ack=0 busy=1", prn_ack, prn_busy); end
        tick();                                               // N+7
        n_assert++; if (prn_busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_N7: got %b want 0", prn_busy); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        n_assert++; if (fifo_level !== 5'd0) begin n_fail++; $display("FAIL single_pop_level: got %0d want 0", fifo_level); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        n_assert++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL full_level: got %0d want 16", fifo_level); end
        prn_data = 8'hAA; prn_strobe = 1'b1;
        repeat (6) tick();
        n_assert++; if (prn_busy !== 1'b1 || prn_ack !== 1'b0) begin n_fail++; $display("FAIL stall_hs: got busy=%b ack=%b want busy=1 ack=0", prn_busy, prn_ack); end
        n_assert++; if (fifo_level !== 5'd16) begin n_fail++; $display("FAIL stall_level: got %0d want 16", fifo_level); end
        n_assert++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL stall_head: got %h want 00", out_data); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;           // pop while full
        n_assert++; if (fifo_level !== 5'd15 || prn_ack !== 1'b0) begin n_fail++; $display("FAIL unstall_P1: got level=%0d ack=%b want 15/0", fifo_level, prn_ack); end
        tick();
        n_assert++; if (fifo_level !== 5'd16 || prn_ack !== 1'b1) begin n_fail++; $display("FAIL unstall_P2: got level=%0d ack=%b want 16/1", fifo_level, prn_ack); end
        prn_strobe = 1'b0;
        for (int k = 0; k < 20 && prn_busy; k++) tick();
        n_assert++; if (prn_busy !== 1'b0) begin n_fail++; $display("FAIL unstall_release: busy=%b want 0", prn_busy); end
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            exp = (i < 16) ? 8'(i) : 8'hAA;
            n_assert++; if (out_valid !== 1'b1 || out_data !== exp) begin n_fail++; $display("FAIL drain_%0d: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp); end
            tick();
        end
        out_ready = 1'b0;
        n_assert++; if (out_valid !== 1'b0 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL drain_empty: got v=%b level=%0d want 0/0", out_valid, fifo_level); end
    endtask

    task automatic test_proto_err();
        prn_data = 8'h11; prn_strobe = 1'b1;                  // N
        tick(); tick();                                       // N+2, ACK
        prn_strobe = 1'b0;
        tick();                                               // N+3, still ACK
        prn_strobe = 1'b1; prn_data = 8'hBB;                  // illegal rise
        tick();                                               // N+4
        n_assert++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_set: got %b want 1", proto_err); end
        prn_strobe = 1'b0;
        for (int k = 0; k < 20 && prn_busy; k++) tick();
        n_assert++; if (fifo_level !== 5'd1 || out_data !== 8'h11) begin n_fail++; $display("FAIL proto_one_byte: got level=%0d d=%h want 1/11", fifo_level, out_data); end
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_assert++; if (proto_err !== 1'b0) begin n_fail++; $display("FAIL proto_clr: got %b want 0", proto_err); end
        // Clear asserted in the same cycle as a new violation: the set must win.
        prn_data = 8'h22; prn_strobe = 1'b1;
        tick(); tick();
        prn_strobe = 1'b0;
        tick();
        prn_strobe = 1'b1; err_clr = 1'b1;
        tick();
        err_clr = 1'b0; prn_strobe = 1'b0;
        n_assert++; if (proto_err !== 1'b1) begin n_fail++; $display("FAIL proto_set_wins: got %b want 1", proto_err); end
        for (int k = 0; k < 20 && prn_busy; k++) tick();
        n_assert++; if (fifo_level !== 5'd2) begin n_fail++; $display("FAIL proto_level2: got %0d want 2", fifo_level); end
        err_clr = 1'b1; out_ready = 1'b1; tick(); tick(); err_clr = 1'b0; out_ready = 1'b0;
        n_assert++; if (proto_err !== 1'b0 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL proto_cleanup: got err=%b level=%0d want 0/0", proto_err, fifo_level); end
    endtask

    task automatic test_enable();
        enable = 1'b0; prn_data = 8'h77; prn_strobe = 1'b1;
        repeat (4) tick();
        n_assert++; if (prn_busy !== 1'b0 || fifo_level !== 5'd0) begin n_fail++; $display("FAIL disabled: got busy=%b level=%0d want 0/0", prn_busy, fifo_level); end
        prn_strobe = 1'b0; enable = 1'b1;
        tick();
        prn_data = 8'h44; prn_strobe = 1'b1;                  // N
        tick(); tick();                                       // N+2
        n_assert++; if (prn_ack !== 1'b1) begin n_fail++; $display("FAIL en_drop_ack: got %b want 1", prn_ack); end
        enable = 1'b0; prn_strobe = 1'b0;
        repeat (5) tick();                                    // N+7
        n_assert++; if (prn_busy !== 1'b0 || fifo_level !== 5'd1 || out_data !== 8'h44) begin n_fail++; $display("FAIL en_drop_done: got busy=%b level=%0d d=%h want 0/1/44", prn_busy, fifo_level, out_data); end
        enable = 1'b1; out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_timeout();
        prn_data = 8'h99; prn_strobe = 1'b1;
        for (int k = 0; k < 20 && !prn_ack; k++) tick();
        for (int k = 0; k < 20 && prn_ack; k++) tick();
        n_assert++; if (prn_busy !== 1'b1 || prn_ack !== 1'b0) begin n_fail++; $display("FAIL to_waitrel: got busy=%b ack=%b want 1/0", prn_busy, prn_ack); end
`ifdef GX4000_PRN_TIMEOUT_EN
        for (int k = 0; k < 5000 && prn_busy; k++) tick();
        n_assert++; if (prn_busy !== 1'b0 || timeout_err !== 1'b1) begin n_fail++; $display("FAIL to_fire: got busy=%b terr=%b want 0/1", prn_busy, timeout_err); end
        repeat (3) tick();
        n_assert++; if (prn_busy !== 1'b0 || fifo_level !== 5'd1) begin n_fail++; $display("FAIL to_no_recap: got busy=%b level=%0d want 0/1", prn_busy, fifo_level); end
        prn_strobe = 1'b0; tick();
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        n_assert++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_clr: got %b want 0", timeout_err); end
`else
        repeat (4200) tick();
        n_assert++; if (prn_busy !== 1'b1 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL to_hold: got busy=%b terr=%b want 1/0", prn_busy, timeout_err); end
        prn_strobe = 1'b0; tick(); tick();
        n_assert++; if (prn_busy !== 1'b0) begin n_fail++; $display("FAIL to_release: got %b want 0", prn_busy); end
`endif
        n_assert++; if (out_data !== 8'h99 || fifo_level !== 5'd1) begin n_fail++; $display("FAIL to_byte: got d=%h level=%0d want 99/1", out_data, fifo_level); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_strobe_held();
        test_single_byte();
        test_back_to_back();
        test_proto_err();
        test_enable();
        test_timeout();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit, got running want finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/gx4000_printer_sink.md
Name: gx4000_printer_sink

Overview:
Peripheral-side Centronics endpoint: the printer that terminates the GX4000/Plus printer port driven by the I/O block.
- Inputs: the host's prn_data and level-style prn_strobe. The host holds strobe high until it sees ack.
- Outputs: prn_busy/prn_ack back to the host.
- Captured bytes are buffered in a FIFO and drained by a downstream consumer (HPS file writer / debug capture).
- Sits in the Amstrad top level, on the far side of the printer_* wires.

Parameters:
FIFO_DEPTH, 16, bytes buffered; power of two, >=2
ACK_CYCLES, 4, clk_sys cycles prn_ack is held high per byte; >=1
TIMEOUT_CYCLES, 4096, strobe-release timeout (used only with the optional feature)

Ports:
clk_sys  in  1  system clock, single clock domain
reset_n  in  1  synchronous, active-low reset
enable  in  1  gx4000_mode|plus_mode; 0 = ignore new strobes
prn_data  in  8  host printer data
prn_strobe  in  1  host strobe, active high, level held until ack
prn_busy  out  1  peripheral busy
prn_ack  out  1  acknowledge pulse
out_data  out  8  FIFO head byte (first-word-fall-through)
out_valid  out  1  FIFO non-empty
out_ready  in  1  consumer pops when out_valid&out_ready
fifo_level  out  $clog2(FIFO_DEPTH+1)  bytes held
proto_err  out  1  sticky: strobe rising edge while not IDLE
timeout_err  out  1  sticky: strobe not released in time (0 without macro)
err_clr  in  1  clears both sticky errors

Behaviour:
Reset (reset_n=0 at a clock edge):
- state=IDLE; prn_busy=0, prn_ack=0.
- FIFO emptied: out_valid=0, fifo_level=0.
- proto_err=0, timeout_err=0.
- strobe_q=1, so a strobe already high at reset release is ignored until it drops.
- Reset mid-transaction discards the hold register. No ack is produced.

Strobe detection:
- strobe_q registers prn_strobe every cycle.
- rise = prn_strobe & ~strobe_q.

States:
- IDLE:
  - busy=0, ack=0.
  - On rise & enable: hold<=prn_data, go CAPTURE.
  - On rise & !enable: nothing.
- CAPTURE:
  - busy=1.
  - If FIFO not full: write hold, go ACK, ack counter=ACK_CYCLES-1.
  - If full: stay (stall). busy stays high indefinitely; no data is lost.
  - Full is evaluated before any same-cycle pop, so a pop while full frees space for the next cycle.
- ACK:
  - busy=1, ack=1.
  - Counter decrements; at 0 go WAIT_REL.
- WAIT_REL:
  - busy=1, ack=0.
  - When prn_strobe==0, go IDLE.
  - This state may last one cycle, since the host drops strobe on ack.

Timing (rise seen at cycle N, FIFO has space):
- prn_busy=1 from N+1.
- FIFO write at end of N+1; out_valid=1 from N+2.
- prn_ack=1 for cycles N+2 .. N+1+ACK_CYCLES.
- With strobe already low, prn_busy=0 at N+3+ACK_CYCLES.

Boundary conditions:
- A rise outside IDLE sets proto_err and is otherwise ignored.
- err_clr and a simultaneous set: set wins.
- enable falling mid-transaction: the current byte completes normally.

FIFO:
- Circular, pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop when not full and not empty: level unchanged.
- Pop when empty is ignored.

Optional Feature:
Macro GX4000_PRN_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT_REL.
  - If strobe is still high after TIMEOUT_CYCLES, set timeout_err and return to IDLE.
  - strobe_q stays 1, so there is no re-capture until strobe falls and rises again.
- Undefined:
  - WAIT_REL waits indefinitely.
  - timeout_err is tied to 0.
  - No counter logic exists.

Decomposition:
- Package gx4000_prn_pkg: state enum (IDLE, CAPTURE, ACK, WAIT_REL), default ACK_CYCLES/FIFO_DEPTH constants, level-width function.
- Sub-module gx4000_prn_fifo: sync FWFT FIFO with push/pop/full/empty/level.
- The FSM and strobe/error logic stay in the top block.

Test Plan:
- Single byte 0x5A (strobe rise at N, host drops strobe on ack) -> busy at N+1; ack high N+2..N+5; out_data=0x5A with out_valid at N+2; busy low at N+7.
- 16 bytes 0x00..0x0F with out_ready=0, then a 17th byte 0xAA -> fifo_level=16; busy stays high and no ack for 0xAA. Pop one -> next cycle 0xAA written, ack follows, level=16; drain yields 0x00..0x0F then 0xAA.
- Strobe held high through reset release -> no capture, fifo_level=0. Strobe low then high with data 0x33 -> 0x33 captured.
- Second strobe rise injected during ACK -> proto_err=1, only one byte in FIFO. err_clr pulse -> proto_err=0.
- enable=0 with a strobe rise for 0x77 -> busy stays 0, nothing captured. enable drops during ACK -> that byte completes.
- GX4000_PRN_TIMEOUT_EN defined, strobe stuck high after ack for 4096 cycles -> timeout_err=1, state IDLE, busy=0. Undefined -> busy stays 1 and timeout_err=0.
